power_sched: RTL

//  Shares one iterative power engine (result = data^exp, one multiply/cycle) between NREQ requesters.

---
 rtl/power_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/power_sched.sv
// power_sched: round-robin arbiter sharing one iterative power engine
// (result = data^exp mod 2^RW, one multiply per cycle) between NREQ requesters.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req             per-requester request, held with operands until ack
//   req_data        base operands, requester i at [i*DW +: DW]
//   req_exp         exponents, requester i at [i*EW +: EW]
//   ack             one-hot 1-cycle pulse when a requester's operands are taken
//   busy            engine not idle
//   resp_valid      response available; resp_ready accepts it
//   resp_id         index of the requester served
//   resp_result     data^exp mod 2^RW
//   resp_ovf        some intermediate product needed more than RW bits
module power_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int EW   = 3,
    parameter int RW   = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       req_data,
    input  logic [NREQ*EW-1:0]       req_exp,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [RW-1:0]            resp_result,
    output logic                     resp_ovf
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = RW + DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [DW-1:0]   data_q, data_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   cnt_q, cnt_d;

    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;
    logic [PW-1:0]   prod;

    function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int k);
        return IW'((int'(a) + k) % NREQ);
    endfunction

    // Scan from the highest offset down so the nearest set request
    // at or after rr_ptr is the one left standing.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr_q, k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        data_d   = data_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        ack      = '0;
        prod     = PW'(acc_q) * PW'(data_q);
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    ack[gnt_idx] = 1'b1;
                    id_d    = gnt_idx;
                    data_d  = req_data[gnt_idx*DW +: DW];
                    cnt_d   = req_exp[gnt_idx*EW +: EW];
                    acc_d   = RW'(1);
                    ovf_d   = 1'b0;
                    state_d = (req_exp[gnt_idx*EW +: EW] == '0) ? DONE : MUL;
                end
            end
            MUL: begin
                acc_d = prod[RW-1:0];
                ovf_d = ovf_q | (|prod[PW-1:RW]);
                cnt_d = cnt_q - EW'(1);
                if (cnt_q == EW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_add(id_q, 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign resp_valid  = (state_q == DONE);
    assign resp_id     = id_q;
    assign resp_result = acc_q;
    assign resp_ovf    = ovf_q;

endmodule
